dot_product_scheduler: RTL and testbench
========================================

Name: dot_product_scheduler

Overview:
Shares one streaming dot_product engine among NUM_REQ requesters using round-robin arbitration. It captures the granted requester's full vector pair and streams it into the engine one element per cycle. It then waits for the engine's self-drained result and returns it to that requester with a one-cycle done pulse. It sits between the compute clients and the single dot_product instance; the engine shares clk and rst_n.

Parameters:
WIDTH, 8, element width in bits
N, 4, elements per vector
NUM_REQ, 2, number of requesters (>=2)
TIMEOUT, 16, maximum cycles spent in WAIT before the job is aborted (must be > N+5)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  level request, one bit per requester
a_flat  in  NUM_REQ*WIDTH*N  requester r's vector A at slice r; element i at [i*WIDTH +: WIDTH] within the slice
b_flat  in  NUM_REQ*WIDTH*N  vector B, same layout as a_flat
grant  out  NUM_REQ  one-hot; high for the granted requester from FEED through WAIT
done  out  NUM_REQ  one-hot, single-cycle completion pulse
err  out  1  high with done when the job timed out
result_out  out  RES_W  result of the last completed job; RES_W = 2*WIDTH+$clog2(N)
eng_input_valid  out  1  to engine input_valid
eng_a  out  WIDTH  to engine A_vec
eng_b  out  WIDTH  to engine B_vec
eng_result  in  RES_W  from engine result
eng_output_valid  in  1  from engine output_valid

Behaviour:
- Reset (async, rst_n=0): state=IDLE; grant, done, err, result_out, eng_input_valid, eng_a, eng_b all 0; element index 0; timeout counter 0; round-robin pointer = 0, so requester 0 has highest priority first.
- States: IDLE, FEED, WAIT, RESP.
- IDLE:
  - Samples req at each edge.
  - If any bit is set, pick the first set bit searching from the pointer upward with wrap.
  - Capture that requester's a/b slices into internal buffers.
  - Set grant[g] and go to FEED.
  - If no bit is set, stay in IDLE.
- FEED (exactly N cycles):
  - Element index k runs 0..N-1.
  - Drive eng_input_valid=1, eng_a = captured A[k], eng_b = captured B[k].
  - After k=N-1, go to WAIT. eng_input_valid=0 and eng_a/eng_b=0 from the first WAIT cycle.
- Timing: req sampled at edge T gives grant high and element 0 on the engine during cycle T+1; element N-1 is driven during T+N.
- WAIT:
  - Counts cycles.
  - On eng_output_valid=1, register eng_result into result_out, set err=0, go to RESP.
  - If the count reaches TIMEOUT with no eng_output_valid, set result_out=0, err=1, go to RESP.
- RESP (one cycle):
  - done[g]=1 (err as registered); grant=0.
  - Pointer = (g+1) mod NUM_REQ.
  - Next state IDLE.
  - done, err and the result_out update become visible together in the RESP cycle.
- result_out holds its value until the next RESP.
- Minimum turnaround is one IDLE cycle between jobs; a requester holding req continuously is re-served only after the other pending requesters have had a turn.
- The captured vectors decouple the requester: a_flat/b_flat may change at any time after the grant edge without affecting the job.
- Any eng_output_valid pulse arriving in IDLE, FEED or RESP is ignored.
- A req drop by the granted requester mid-job does not abort the job; done is still pulsed.
- Reset mid-job: all state is cleared immediately; no done pulse is issued for the aborted job.
- Arithmetic: no arithmetic beyond index and counter increments; widths pass straight through. The index and counter saturate at their terminal values, and the timeout counter clears on entry to WAIT.

Decomposition:
- Package dot_product_pkg holds:
  - state enum (IDLE, FEED, WAIT, RESP);
  - the RES_W width function (2*WIDTH+$clog2(N)), shared with the dot_product engine;
  - the TIMEOUT default constant.
- Sub-module rr_arbiter:
  - parameterised by NUM_REQ;
  - inputs: req vector, pointer, enable;
  - output: one-hot grant;
  - purely combinational pick; the pointer is registered in the scheduler.

Test Plan:
1. Single request: after reset, req=01, A0=[1,1,1,1], B0=[1,1,1,1] -> grant=01 from T+1; eng_input_valid high exactly 4 cycles with elements 1/1; done=01 pulse with result_out=4, err=0.
2. Simultaneous requests: req=11 with A0·B0=[1,2,3,4]·[10,1,0,2] and A1·B1=[255×4]·[1×4] -> requester 0 served first (done=01, result 20), then requester 1 (done=10, result 1020).
3. Fairness: both req held high for 4 jobs -> grant order 0,1,0,1; exactly one IDLE cycle between each RESP and the next FEED.
4. Timeout: engine stub never asserts output_valid -> TIMEOUT cycles after entering WAIT, done pulses with err=1, result_out=0, and the scheduler returns to IDLE and serves the next request normally.
5. Reset mid-FEED: drop rst_n on the 2nd element -> grant, eng_input_valid and done are 0 immediately; no done pulse; after release, req=10 is served before requester 0 only if req0=0.
6. Capture isolation: change a_flat[0] to all-zero one cycle after grant, with A=[4,3,2,1] and B=[1,1,1,1] -> result_out=10.

Source files
------------

// File: rtl/dot_product_pkg.sv
// Shared types and helpers for the dot-product scheduler and its engine.
package dot_product_pkg;

  // Scheduler job phases
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  // Default number of WAIT cycles before a job is abandoned
  localparam int TIMEOUT_DEFAULT = 16;

  // Result width of an N-element dot product of WIDTH-bit operands
  function automatic int res_width(input int width, input int n);
    return 2 * width + $clog2(n);
  endfunction

endpackage

// File: rtl/dot_product_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, with wrap.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant
);

  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);

  logic             w_found;
  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;

  // Walk the requesters starting at the pointer; the first hit wins.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, i_ptr} + (PTR_W + 1)'(i);
      if (w_sum >= NUM_REQ_W) begin
        w_sum = w_sum - NUM_REQ_W;
      end
      w_idx = w_sum[PTR_W-1:0];
      if (i_en && !w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dot_product_scheduler.sv
// Shares one streaming dot-product engine among NUM_REQ requesters.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no job; arbitrate over req and capture the winner's vectors
// FEED  | stream captured element k (0..N-1) into the engine
// WAIT  | wait for engine output_valid or for the timeout to expire
// RESP  | one-cycle done pulse to the owner; advance the RR pointer
module dot_product_scheduler
  import dot_product_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int N       = 4,
  parameter  int NUM_REQ = 2,
  parameter  int TIMEOUT = TIMEOUT_DEFAULT,
  localparam int RES_W   = res_width(WIDTH, N)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH*N-1:0] a_flat,
  input  logic [NUM_REQ*WIDTH*N-1:0] b_flat,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic                       err,
  output logic [RES_W-1:0]           result_out,
  output logic                       eng_input_valid,
  output logic [WIDTH-1:0]           eng_a,
  output logic [WIDTH-1:0]           eng_b,
  input  logic [RES_W-1:0]           eng_result,
  input  logic                       eng_output_valid
);

  localparam int SLICE_W = WIDTH * N;
  localparam int PTR_W   = $clog2(NUM_REQ);
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W   = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [PTR_W-1:0]           r_ptr;
  logic [PTR_W-1:0]           r_gidx;
  logic [NUM_REQ-1:0]         r_grant;
  logic [NUM_REQ-1:0]         r_done;
  logic                       r_err;
  logic [RES_W-1:0]           r_result;
  logic [N-1:0][WIDTH-1:0]    r_a;
  logic [N-1:0][WIDTH-1:0]    r_b;
  logic [IDX_W-1:0]           r_idx;
  logic [CNT_W-1:0]           r_cnt;

  logic                       w_any_req;
  logic                       w_arb_en;
  logic [NUM_REQ-1:0]         w_arb_gnt;
  logic [PTR_W-1:0]           w_gidx;
  logic [SLICE_W-1:0]         w_a_sel;
  logic [SLICE_W-1:0]         w_b_sel;
  logic                       w_feed_last;
  logic                       w_timeout;

  assign w_any_req   = |req;
  assign w_arb_en    = (r_state == IDLE);
  assign w_feed_last = (r_idx == IDX_LAST);
  assign w_timeout   = (r_cnt == CNT_LAST);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .i_en    (w_arb_en),
    .o_grant (w_arb_gnt)
  );

  // Encode the one-hot winner and select its vector slices for capture.
  always_comb begin
    w_gidx  = '0;
    w_a_sel = '0;
    w_b_sel = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_arb_gnt[j]) begin
        w_gidx  = PTR_W'(j);
        w_a_sel = a_flat[j*SLICE_W +: SLICE_W];
        w_b_sel = b_flat[j*SLICE_W +: SLICE_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; engine valid is only honoured while waiting.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_any_req) w_state_nxt = FEED;
      FEED: if (w_feed_last) w_state_nxt = WAIT;
      WAIT: if (eng_output_valid || w_timeout) w_state_nxt = RESP;
      RESP: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Job datapath: capture, element index, timeout counter, response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_gidx   <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_err    <= 1'b0;
      r_result <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant <= w_arb_gnt;
            r_gidx  <= w_gidx;
            r_a     <= w_a_sel;
            r_b     <= w_b_sel;
            r_idx   <= '0;
          end
        end
        FEED: begin
          if (!w_feed_last) begin
            r_idx <= r_idx + 1'b1;
          end else begin
            r_cnt <= '0;
          end
        end
        WAIT: begin
          if (eng_output_valid) begin
            r_result <= eng_result;
            r_err    <= 1'b0;
            r_grant  <= '0;
            r_done   <= r_grant;
          end else if (w_timeout) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_grant  <= '0;
            r_done   <= r_grant;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_done <= '0;
          r_err  <= 1'b0;
          r_ptr  <= (r_gidx == PTR_LAST) ? '0 : r_gidx + 1'b1;
        end
        default: begin
          r_grant <= '0;
          r_done  <= '0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  // Engine drive: captured element k while feeding, zero otherwise.
  always_comb begin
    eng_input_valid = (r_state == FEED);
    eng_a           = '0;
    eng_b           = '0;
    if (r_state == FEED) begin
      eng_a = r_a[r_idx];
      eng_b = r_b[r_idx];
    end
  end

  assign grant      = r_grant;
  assign done       = r_done;
  assign err        = r_err;
  assign result_out = r_result;

endmodule

// File: tb/tb_dot_product_scheduler.sv
// Scoreboard bench for dot_product_scheduler with a behavioural engine model.
module tb_dot_product_scheduler;
  import dot_product_pkg::*;

  localparam int WIDTH   = 8;
  localparam int N       = 4;
  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 16;
  localparam int RES_W   = res_width(WIDTH, N);
  localparam int VEC_W   = WIDTH * N;

  typedef struct {
    logic [NUM_REQ-1:0] done;
    logic [RES_W-1:0]   res;
    logic               err;
  } exp_t;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*VEC_W-1:0]   a_flat;
  logic [NUM_REQ*VEC_W-1:0]   b_flat;
  logic [NUM_REQ-1:0]         grant;
  logic [NUM_REQ-1:0]         done;
  logic                       err;
  logic [RES_W-1:0]           result_out;
  logic                       eng_input_valid;
  logic [WIDTH-1:0]           eng_a;
  logic [WIDTH-1:0]           eng_b;
  logic [RES_W-1:0]           eng_result;
  logic                       eng_output_valid;

  // engine model state
  logic [RES_W-1:0] eng_acc, eng_pend_res, eng_res_q, spur_res;
  logic [2:0]       eng_cnt;
  logic             eng_pend, eng_valid_q, eng_mute, spur;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_valid, n_done, n_grants, last_done_cyc, last_grant_cyc, gap_base;
  int t0, base;
  logic gap_chk;
  logic [NUM_REQ-1:0] prev_grant;
  logic [VEC_W-1:0] va0, vb0, va1, vb1;

  exp_t                 sb_q[$];
  logic [2*WIDTH-1:0]   elem_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dot_product_scheduler #(
    .WIDTH   (WIDTH),
    .N       (N),
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req),
    .a_flat           (a_flat),
    .b_flat           (b_flat),
    .grant            (grant),
    .done             (done),
    .err              (err),
    .result_out       (result_out),
    .eng_input_valid  (eng_input_valid),
    .eng_a            (eng_a),
    .eng_b            (eng_b),
    .eng_result       (eng_result),
    .eng_output_valid (eng_output_valid)
  );

  // Engine: accumulate N elements, present the sum two edges after the last one.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_acc <= '0; eng_pend_res <= '0; eng_res_q <= '0;
      eng_cnt <= '0; eng_pend <= 1'b0; eng_valid_q <= 1'b0;
    end else begin
      eng_valid_q <= 1'b0;
      if (eng_pend) begin
        eng_valid_q <= !eng_mute;
        eng_res_q   <= eng_pend_res;
        eng_pend    <= 1'b0;
      end
      if (eng_input_valid) begin
        if (eng_cnt == 3'(N - 1)) begin
          eng_pend     <= 1'b1;
          eng_pend_res <= eng_acc + RES_W'(eng_a) * RES_W'(eng_b);
          eng_acc      <= '0;
          eng_cnt      <= '0;
        end else begin
          eng_acc <= eng_acc + RES_W'(eng_a) * RES_W'(eng_b);
          eng_cnt <= eng_cnt + 3'd1;
        end
      end
    end
  end

  assign eng_output_valid = eng_valid_q | spur;
  assign eng_result       = spur ? spur_res : eng_res_q;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RES_W-1:0] dot(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    logic [RES_W-1:0] s = '0;
    for (int i = 0; i < N; i++) s += RES_W'(a[i*WIDTH +: WIDTH]) * RES_W'(b[i*WIDTH +: WIDTH]);
    return s;
  endfunction

  task automatic set_vec(input int r, input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    a_flat[r*VEC_W +: VEC_W] = a;
    b_flat[r*VEC_W +: VEC_W] = b;
  endtask

  task automatic push_job(input int r, input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                          input logic err_exp);
    exp_t e;
    for (int i = 0; i < N; i++) elem_q.push_back({a[i*WIDTH +: WIDTH], b[i*WIDTH +: WIDTH]});
    e.done = NUM_REQ'(1 << r);
    e.res  = err_exp ? '0 : dot(a, b);
    e.err  = err_exp;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_grant_rise();
    int k = 0;
    while (grant != 0 && k < 100) begin @(negedge clk); k++; end
    while (grant == 0 && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) check_val("grant_wait_bound", 64'(k), 64'd0);
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (n_done < target && k < 200) begin @(negedge clk); k++; end
    check_val("done_count", 64'(n_done), 64'(target));
  endtask

  // Monitor: element stream, grant timing and completion scoreboard.
  always @(negedge clk) begin
    logic [2*WIDTH-1:0] e;
    exp_t x;
    if (rst_n) begin
      if (eng_input_valid) begin
        n_valid++;
        if (elem_q.size() == 0) begin
          check_val("elem_q_size", 64'(elem_q.size()), 64'd1);
        end else begin
          e = elem_q.pop_front();
          check_val("eng_a", 64'(eng_a), 64'(e[2*WIDTH-1:WIDTH]));
          check_val("eng_b", 64'(eng_b), 64'(e[WIDTH-1:0]));
        end
      end
      if (grant != 0 && prev_grant == 0) begin
        n_grants++;
        last_grant_cyc = cyc;
        if (gap_chk && n_done > gap_base)
          check_val("idle_gap", 64'(cyc - last_done_cyc), 64'd2);
      end
      if (done != 0) begin
        if (sb_q.size() == 0) begin
          check_val("sb_q_size", 64'(sb_q.size()), 64'd1);
        end else begin
          x = sb_q.pop_front();
          check_val("done_vec", 64'(done), 64'(x.done));
          check_val("err", 64'(err), 64'(x.err));
          check_val("result", 64'(result_out), 64'(x.res));
        end
        n_done++;
        last_done_cyc = cyc;
      end
    end
    prev_grant = grant;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_valid = 0; n_done = 0; n_grants = 0; last_done_cyc = 0; last_grant_cyc = 0;
    gap_base = 0; gap_chk = 1'b0; prev_grant = '0;
    eng_mute = 1'b0; spur = 1'b0; spur_res = '0;
    rst_n = 1'b0;
    req = '0;
    a_flat = {NUM_REQ{32'hA5C3_7E19}};
    b_flat = {NUM_REQ{32'h3C5A_9617}};
    repeat (3) @(negedge clk);

    // reset state
    check_val("rst_grant", 64'(grant), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_err", 64'(err), 64'd0);
    check_val("rst_result", 64'(result_out), 64'd0);
    check_val("rst_eng_valid", 64'(eng_input_valid), 64'd0);
    check_val("rst_eng_a", 64'(eng_a), 64'd0);
    check_val("rst_eng_b", 64'(eng_b), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single request
    set_vec(0, 32'h01010101, 32'h01010101);
    push_job(0, 32'h01010101, 32'h01010101, 1'b0);
    n_valid = 0;
    req = 2'b01;
    t0 = cyc;
    wait_grant_rise();
    check_val("t1_grant_lat", 64'(cyc - t0), 64'd1);
    check_val("t1_grant", 64'(grant), 64'd1);
    req = 2'b00;
    wait_done(1);
    repeat (3) @(negedge clk);
    check_val("t1_valid_cycles", 64'(n_valid), 64'd4);
    check_val("t1_done_once", 64'(n_done), 64'd1);

    // 2: simultaneous requests, requester 0 first
    do_reset();
    va0 = 32'h04030201; vb0 = 32'h0200010A;
    va1 = 32'hFFFFFFFF; vb1 = 32'h01010101;
    set_vec(0, va0, vb0); set_vec(1, va1, vb1);
    push_job(0, va0, vb0, 1'b0);
    push_job(1, va1, vb1, 1'b0);
    base = n_done; gap_base = n_done; gap_chk = 1'b1;
    req = 2'b11;
    wait_grant_rise();
    wait_grant_rise();
    req = 2'b00;
    wait_done(base + 2);
    gap_chk = 1'b0;

    // 3: fairness with both requests held for four jobs
    do_reset();
    va0 = VEC_W'($urandom); vb0 = VEC_W'($urandom);
    va1 = VEC_W'($urandom); vb1 = VEC_W'($urandom);
    set_vec(0, va0, vb0); set_vec(1, va1, vb1);
    for (int j = 0; j < 4; j++) begin
      if (j % 2 == 0) push_job(0, va0, vb0, 1'b0);
      else            push_job(1, va1, vb1, 1'b0);
    end
    base = n_done; gap_base = n_done; gap_chk = 1'b1;
    req = 2'b11;
    repeat (4) wait_grant_rise();
    req = 2'b00;
    wait_done(base + 4);
    gap_chk = 1'b0;

    // 4: engine never answers, then normal service resumes
    do_reset();
    eng_mute = 1'b1;
    va0 = 32'h05060708; vb0 = 32'h01020304;
    set_vec(0, va0, vb0);
    push_job(0, va0, vb0, 1'b1);
    base = n_done;
    req = 2'b01;
    wait_grant_rise();
    t0 = cyc;
    req = 2'b00;
    wait_done(base + 1);
    check_val("t4_timeout_lat", 64'(last_done_cyc - t0), 64'(N + TIMEOUT));
    eng_mute = 1'b0;
    va1 = 32'h11223344; vb1 = 32'h02020202;
    set_vec(1, va1, vb1);
    push_job(1, va1, vb1, 1'b0);
    req = 2'b10;
    wait_grant_rise();
    req = 2'b00;
    wait_done(base + 2);

    // 5: reset on the second element
    do_reset();
    va0 = 32'h09080706; vb0 = 32'h03030303;
    set_vec(0, va0, vb0);
    for (int i = 0; i < 2; i++) elem_q.push_back({va0[i*WIDTH +: WIDTH], vb0[i*WIDTH +: WIDTH]});
    req = 2'b01;
    wait_grant_rise();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("t5_grant", 64'(grant), 64'd0);
    check_val("t5_eng_valid", 64'(eng_input_valid), 64'd0);
    check_val("t5_done", 64'(done), 64'd0);
    base = n_done;
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_val("t5_no_done", 64'(n_done), 64'(base));
    va1 = 32'h0A0B0C0D; vb1 = 32'h01000201;
    set_vec(1, va1, vb1);
    push_job(1, va1, vb1, 1'b0);
    req = 2'b10;
    wait_grant_rise();
    check_val("t5_grant1", 64'(grant), 64'd2);
    req = 2'b00;
    wait_done(base + 1);

    // 6: capture isolation, result hold, stray engine valid in IDLE
    va0 = 32'h01020304; vb0 = 32'h01010101;
    set_vec(0, va0, vb0);
    push_job(0, va0, vb0, 1'b0);
    base = n_done;
    req = 2'b01;
    wait_grant_rise();
    @(negedge clk);
    a_flat[VEC_W-1:0] = '0;
    req = 2'b00;
    wait_done(base + 1);
    repeat (3) @(negedge clk);
    check_val("t6_hold", 64'(result_out), 64'd10);
    spur_res = 18'h2AAAA;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    check_val("t6_spur_no_done", 64'(n_done), 64'(base + 1));
    check_val("t6_spur_hold", 64'(result_out), 64'd10);
    check_val("sb_drained", 64'(sb_q.size()), 64'd0);
    check_val("elem_drained", 64'(elem_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
